// File: rtl/mem_bus_arbiter_if.sv
// Core-side (IF, LSU) and memory-side signals of mem_bus_arbiter.
// Every *_req channel transfers on a rising edge where valid and ready are both high. The sender holds
// valid and its fields until then and may drop valid earlier. Every *_rsp_valid is a one-cycle pulse.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;

    logic              lsu_req_valid;
    logic              lsu_req_we;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_req_ready;
    logic              lsu_rsp_valid;
    logic [DATA_W-1:0] lsu_rsp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between IF and LSU, with one transaction outstanding at a time.
// Define MEM_BUS_ARB_RR_EN for round-robin tie-breaking. Without it, the LSU has fixed priority.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus,
    output logic             busy,
    output logic             owner,
    output logic             err_timeout,
    output logic             err_spurious,
    output logic [1:0]       state_dbg
);
    localparam int         MASK_W   = DATA_W / 8;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state, next_state;
    logic              grant_if, grant_lsu;
    logic              accept, issue_fire, rsp_done, timeout_hit;
    logic [7:0]        wait_cnt;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_mask;
    logic              owner_r;
    logic              if_rsp_valid_r, lsu_rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;

`ifdef MEM_BUS_ARB_RR_EN
    logic last_owner;

    // On a tie, the requester that did not win last time gets the grant.
    always_comb begin
        grant_lsu = bus.lsu_req_valid && (!bus.if_req_valid || !last_owner);
        grant_if  = bus.if_req_valid && !grant_lsu;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_owner <= 1'b1;
        else if (accept) last_owner <= grant_lsu;
    end
`else
    assign grant_lsu = bus.lsu_req_valid;
    assign grant_if  = bus.if_req_valid && !bus.lsu_req_valid;
`endif

    assign accept      = (state == IDLE) && (grant_if || grant_lsu);
    assign issue_fire  = (state == ISSUE) && bus.mem_req_ready;
    assign rsp_done    = (state == WAIT) && bus.mem_rsp_valid;
    assign timeout_hit = (state == WAIT) && !bus.mem_rsp_valid && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   if (bus.mem_req_ready) next_state = WAIT;
            WAIT:    if (rsp_done || timeout_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Readies are held low while reset is asserted, even if a requester is already valid.
    assign bus.if_req_ready  = (state == IDLE) && grant_if && !rst;
    assign bus.lsu_req_ready = (state == IDLE) && grant_lsu && !rst;
    assign bus.mem_req_valid = (state == ISSUE);
    assign bus.mem_req_we    = req_we;
    assign bus.mem_req_addr  = req_addr;
    assign bus.mem_req_wdata = req_wdata;
    assign bus.mem_req_wmask = req_mask;
    assign bus.if_rsp_valid  = if_rsp_valid_r;
    assign bus.if_rsp_data   = rsp_data_r;
    assign bus.lsu_rsp_valid = lsu_rsp_valid_r;
    assign bus.lsu_rsp_data  = rsp_data_r;
    assign busy              = (state != IDLE);
    assign owner             = owner_r;
    assign state_dbg         = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_we          <= 1'b0;
            req_addr        <= '0;
            req_wdata       <= '0;
            req_mask        <= '0;
            owner_r         <= 1'b0;
            wait_cnt        <= 8'd0;
            if_rsp_valid_r  <= 1'b0;
            lsu_rsp_valid_r <= 1'b0;
            rsp_data_r      <= '0;
            err_timeout     <= 1'b0;
            err_spurious    <= 1'b0;
        end else begin
            if_rsp_valid_r  <= 1'b0;
            lsu_rsp_valid_r <= 1'b0;
            err_timeout     <= 1'b0;

            if (accept) begin
                owner_r <= grant_lsu;
                if (grant_lsu) begin
                    req_we    <= bus.lsu_req_we;
                    req_addr  <= bus.lsu_req_addr;
                    req_wdata <= bus.lsu_req_wdata;
                    req_mask  <= bus.lsu_req_wmask;
                end else begin
                    req_we    <= 1'b0;
                    req_addr  <= bus.if_req_addr;
                    req_wdata <= '0;
                    req_mask  <= '1;
                end
            end

            if (issue_fire)           wait_cnt <= 8'd0;
            else if (state == WAIT)   wait_cnt <= wait_cnt + 8'd1;

            // A timeout completes like a response carrying zero data.
            if (rsp_done || timeout_hit) begin
                rsp_data_r      <= (rsp_done && !req_we) ? bus.mem_rsp_data : '0;
                if_rsp_valid_r  <= !owner_r;
                lsu_rsp_valid_r <= owner_r;
            end
            if (timeout_hit) err_timeout <= 1'b1;

            if (bus.mem_rsp_valid && (state != WAIT)) err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 64;
    localparam int TIMEOUT_CYC = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy, owner, err_timeout, err_spurious;
    logic [1:0] state_dbg;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .owner(owner),
        .err_timeout(err_timeout), .err_spurious(err_spurious), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endfunction

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        bit          owner;
        bit          we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        bit          issued;
        int          waited;
    } txn_t;

    txn_t        act_q[$];
    txn_t        t_cur;
    bit          m_owner, m_if_rsp, m_lsu_rsp, m_err_to, m_err_sp;
    logic [63:0] m_rsp_data;
`ifdef MEM_BUS_ARB_RR_EN
    bit          m_last_owner;
`endif
    bit          if_acc, lsu_acc, model_waiting, model_busy;
    bit          e_busy, e_mem_valid, waiting_now;
    int          win;

    function automatic int pick(logic iv, logic lv);
        if (iv && lv) begin
`ifdef MEM_BUS_ARB_RR_EN
            return m_last_owner ? 0 : 1;
`else
            return 1;
`endif
        end
        if (lv) return 1;
        if (iv) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        act_q.delete();
        m_owner = 0; m_if_rsp = 0; m_lsu_rsp = 0; m_err_to = 0; m_err_sp = 0;
        m_rsp_data = '0;
`ifdef MEM_BUS_ARB_RR_EN
        m_last_owner = 1;
`endif
        if_acc = 0; lsu_acc = 0; model_waiting = 0; model_busy = 0;
    endtask

    // Single compare process: check what the model says this cycle, then advance the model one edge.
    always @(negedge clk) begin
        if (rst) model_reset();
        e_busy      = (act_q.size() != 0);
        waiting_now = 0;
        e_mem_valid = 0;
        if (e_busy) begin
            waiting_now = act_q[0].issued;
            e_mem_valid = !act_q[0].issued;
        end
        win = (rst || e_busy) ? -1 : pick(bus.if_req_valid, bus.lsu_req_valid);

        chk("if_req_ready", bus.if_req_ready, 64'(win == 0));
        chk("lsu_req_ready", bus.lsu_req_ready, 64'(win == 1));
        chk("mem_req_valid", bus.mem_req_valid, 64'(e_mem_valid));
        chk("busy", busy, 64'(e_busy));
        chk("state_dbg_idle", 64'(state_dbg == 2'd0), 64'(!e_busy));
        chk("owner", owner, 64'(m_owner));
        chk("if_rsp_valid", bus.if_rsp_valid, 64'(m_if_rsp));
        chk("lsu_rsp_valid", bus.lsu_rsp_valid, 64'(m_lsu_rsp));
        chk("err_timeout", err_timeout, 64'(m_err_to));
        chk("err_spurious", err_spurious, 64'(m_err_sp));
        if (e_mem_valid) begin
            chk("mem_req_addr", bus.mem_req_addr, 64'(act_q[0].addr));
            chk("mem_req_we", bus.mem_req_we, 64'(act_q[0].we));
            chk("mem_req_wmask", bus.mem_req_wmask, 64'(act_q[0].mask));
            if (act_q[0].we) chk("mem_req_wdata", bus.mem_req_wdata, act_q[0].wdata);
        end
        if (m_if_rsp)  chk("if_rsp_data", bus.if_rsp_data, m_rsp_data);
        if (m_lsu_rsp) chk("lsu_rsp_data", bus.lsu_rsp_data, m_rsp_data);

        if (!rst) begin
            if_acc = 0; lsu_acc = 0;
            m_if_rsp = 0; m_lsu_rsp = 0; m_err_to = 0;
            if (bus.mem_rsp_valid && !waiting_now) m_err_sp = 1;
            if (!e_busy) begin
                if (win >= 0) begin
                    t_cur.owner  = (win == 1);
                    t_cur.we     = (win == 1) ? bus.lsu_req_we : 1'b0;
                    t_cur.addr   = (win == 1) ? bus.lsu_req_addr : bus.if_req_addr;
                    t_cur.wdata  = (win == 1) ? bus.lsu_req_wdata : 64'd0;
                    t_cur.mask   = (win == 1) ? bus.lsu_req_wmask : 8'hFF;
                    t_cur.issued = 0;
                    t_cur.waited = 0;
                    act_q.push_back(t_cur);
                    m_owner = t_cur.owner;
`ifdef MEM_BUS_ARB_RR_EN
                    m_last_owner = t_cur.owner;
`endif
                    if_acc  = (win == 0);
                    lsu_acc = (win == 1);
                end
            end else if (!waiting_now) begin
                if (bus.mem_req_ready) begin
                    t_cur = act_q[0];
                    t_cur.issued = 1;
                    act_q[0] = t_cur;
                end
            end else begin
                t_cur = act_q[0];
                t_cur.waited++;
                if (bus.mem_rsp_valid || t_cur.waited == TIMEOUT_CYC) begin
                    m_rsp_data = (bus.mem_rsp_valid && !t_cur.we) ? bus.mem_rsp_data : 64'd0;
                    m_err_to   = !bus.mem_rsp_valid;
                    m_if_rsp   = !t_cur.owner;
                    m_lsu_rsp  = t_cur.owner;
                    void'(act_q.pop_front());
                end else begin
                    act_q[0] = t_cur;
                end
            end
            model_busy    = (act_q.size() != 0);
            model_waiting = model_busy && act_q[0].issued;
        end
    end

    // ---------------- driver tasks ----------------
    bit silent = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req_valid  = 0; bus.if_req_addr = '0;
        bus.lsu_req_valid = 0; bus.lsu_req_we = 0; bus.lsu_req_addr = '0;
        bus.lsu_req_wdata = '0; bus.lsu_req_wmask = '0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    endtask

    task automatic apply_reset();
        tick();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic drain(string name);
        int n = 0;
        while (model_busy && n < 400) begin
            tick();
            bus.mem_req_ready = 1;
            bus.mem_rsp_valid = model_waiting;
            bus.mem_rsp_data  = {$urandom, $urandom};
            n++;
        end
        bus.mem_rsp_valid = 0;
        @(negedge clk);
        chk(name, busy, 0);
    endtask

    task automatic rand_cycle();
        if (if_acc || !bus.if_req_valid) begin
            bus.if_req_valid = ($urandom_range(0, 2) == 0);
            bus.if_req_addr  = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
            bus.if_req_valid = 0;
        end
        if (lsu_acc || !bus.lsu_req_valid) begin
            bus.lsu_req_valid = ($urandom_range(0, 2) == 0);
            bus.lsu_req_we    = 1'($urandom_range(0, 1));
            bus.lsu_req_addr  = $urandom;
            bus.lsu_req_wdata = {$urandom, $urandom};
            bus.lsu_req_wmask = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
            bus.lsu_req_valid = 0;
        end
        if (if_acc || lsu_acc) silent = ($urandom_range(0, 59) == 0);
        bus.mem_req_ready = ($urandom_range(0, 2) != 0);
        if (model_waiting && !silent) bus.mem_rsp_valid = ($urandom_range(0, 3) == 0);
        else                          bus.mem_rsp_valid = ($urandom_range(0, 299) == 0);
        bus.mem_rsp_data = {$urandom, $urandom};
    endtask

    // ---------------- stimulus ----------------
    logic exp_grant [4];
    int   grants, cyc, n;
    bit   seen;

    initial begin
`ifdef MEM_BUS_ARB_RR_EN
        exp_grant[0] = 0; exp_grant[1] = 1; exp_grant[2] = 0; exp_grant[3] = 1;
`else
        exp_grant[0] = 1; exp_grant[1] = 1; exp_grant[2] = 1; exp_grant[3] = 1;
`endif
        rst = 1;
        clear_inputs();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 0);
        chk("rst_err_spurious", err_spurious, 0);
        tick();
        tick();
        rst = 0;

        // Single IF read, memory ready, response two cycles after issue.
        tick();
        bus.if_req_valid = 1; bus.if_req_addr = 32'h8000_0000; bus.mem_req_ready = 1;
        @(negedge clk);
        chk("t1_if_ready", bus.if_req_ready, 1);
        chk("t1_lsu_ready", bus.lsu_req_ready, 0);
        tick();
        bus.if_req_valid = 0;
        @(negedge clk);
        chk("t1_mem_valid", bus.mem_req_valid, 1);
        chk("t1_mem_addr", bus.mem_req_addr, 64'h8000_0000);
        chk("t1_mem_we", bus.mem_req_we, 0);
        chk("t1_mem_mask", bus.mem_req_wmask, 64'hFF);
        tick();
        tick();
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 64'h1122_3344_5566_7788;
        tick();
        bus.mem_rsp_valid = 0;
        @(negedge clk);
        chk("t1_if_rsp_valid", bus.if_rsp_valid, 1);
        chk("t1_if_rsp_data", bus.if_rsp_data, 64'h1122_3344_5566_7788);
        chk("t1_lsu_rsp_valid", bus.lsu_rsp_valid, 0);
        chk("t1_busy_done", busy, 0);
        tick();
        @(negedge clk);
        chk("t1_if_rsp_one_cycle", bus.if_rsp_valid, 0);

        // LSU write with memory back-pressure for three cycles.
        tick();
        bus.lsu_req_valid = 1; bus.lsu_req_we = 1; bus.lsu_req_addr = 32'h100;
        bus.lsu_req_wdata = 64'hAB; bus.lsu_req_wmask = 8'h01; bus.mem_req_ready = 0;
        @(negedge clk);
        chk("t2_lsu_ready", bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_req_ready = 1;
            @(negedge clk);
            chk($sformatf("t2_valid_%0d", i), bus.mem_req_valid, 1);
            chk($sformatf("t2_addr_%0d", i), bus.mem_req_addr, 64'h100);
            chk($sformatf("t2_we_%0d", i), bus.mem_req_we, 1);
            chk($sformatf("t2_wdata_%0d", i), bus.mem_req_wdata, 64'hAB);
            chk($sformatf("t2_mask_%0d", i), bus.mem_req_wmask, 64'h01);
            tick();
        end
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 64'hFFFF_0000_1234_5678;
        tick();
        bus.mem_rsp_valid = 0;
        @(negedge clk);
        chk("t2_lsu_rsp_valid", bus.lsu_rsp_valid, 1);
        chk("t2_lsu_rsp_data", bus.lsu_rsp_data, 0);
        chk("t2_if_rsp_valid", bus.if_rsp_valid, 0);

        // Both requesters valid every cycle for four transactions.
        apply_reset();
        tick();
        bus.if_req_valid = 1; bus.if_req_addr = 32'h2000;
        bus.lsu_req_valid = 1; bus.lsu_req_we = 0; bus.lsu_req_addr = 32'h3000;
        bus.mem_req_ready = 1;
        grants = 0; cyc = 0;
        while (grants < 4 && cyc < 60) begin
            @(negedge clk);
            if (bus.if_req_ready || bus.lsu_req_ready) begin
                chk($sformatf("t3_grant_%0d", grants), bus.lsu_req_ready, 64'(exp_grant[grants]));
                grants++;
            end
            tick();
            bus.mem_rsp_valid = model_waiting;
            bus.mem_rsp_data  = {$urandom, $urandom};
            cyc++;
        end
        chk("t3_grant_count", grants, 4);
        bus.if_req_valid = 0; bus.lsu_req_valid = 0;
        drain("t3_drained");

        // Timeout: memory never answers, then answers late.
        tick();
        bus.if_req_valid = 1; bus.if_req_addr = 32'h40; bus.mem_req_ready = 1; bus.mem_rsp_valid = 0;
        tick();
        bus.if_req_valid = 0;
        n = 0; seen = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (err_timeout) seen = 1;
        end
        chk("t4_timeout_cycle", n, 257);
        chk("t4_if_rsp_valid", bus.if_rsp_valid, 1);
        chk("t4_if_rsp_data", bus.if_rsp_data, 0);
        chk("t4_busy", busy, 0);
        chk("t4_spurious_before", err_spurious, 0);
        tick();
        bus.mem_rsp_valid = 1;
        tick();
        bus.mem_rsp_valid = 0;
        @(negedge clk);
        chk("t4_err_spurious", err_spurious, 1);
        chk("t4_err_timeout_pulse", err_timeout, 0);

        // Reset while waiting for a response.
        apply_reset();
        tick();
        bus.lsu_req_valid = 1; bus.lsu_req_we = 0; bus.lsu_req_addr = 32'h200; bus.mem_req_ready = 1;
        @(negedge clk);
        chk("t5_lsu_ready", bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 0;
        tick();
        tick();
        rst = 1;
        clear_inputs();
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_mem_valid", bus.mem_req_valid, 0);
        chk("t5_mem_addr", bus.mem_req_addr, 0);
        chk("t5_lsu_rsp_data", bus.lsu_rsp_data, 0);
        chk("t5_err_spurious", err_spurious, 0);
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_no_lsu_rsp_%0d", i), bus.lsu_rsp_valid, 0);
            tick();
        end
        bus.if_req_valid = 1; bus.if_req_addr = 32'h400; bus.mem_req_ready = 1;
        @(negedge clk);
        chk("t5_regrant", bus.if_req_ready, 1);
        tick();
        bus.if_req_valid = 0;
        drain("t5_drained");

        // Randomized traffic, checked by the compare process.
        apply_reset();
        for (int c = 0; c < 6000; c++) begin
            tick();
            if ($urandom_range(0, 999) == 0) apply_reset();
            else rand_cycle();
        end
        bus.if_req_valid = 0; bus.lsu_req_valid = 0;
        silent = 0;
        drain("rand_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded its time limit, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
